uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_fifo.sv | 67 ++++++
 rtl/uart_rx.sv | 148 ++++++++++++++
 tb/tb_uart_rx.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, data width
// and bit-period counter width, common to uart_tx and uart_rx.
package uart_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned IDX_W  = 3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA_BITS = 3'd2,
    STOP_BIT  = 3'd3,
    WAIT_HIGH = 3'd4
  } uart_state_e;

  // Offset from the falling start edge to the middle of a bit period.
  function automatic int unsigned half_bit(input int unsigned cpb);
    return (cpb - 1) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive buffer: head entry is always visible on data_out,
// a push while full is accepted only if a pop frees a slot in the same cycle.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              do_push;
  logic              do_pop;

  // Pointers wrap explicitly so non-power-of-two and depth-1 builds behave.
  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign data_out = empty ? '0 : mem[rd_ptr];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, mid-bit sampling.
// Build option UART_RX_FIFO_EN: when defined the receive buffer holds
// FIFO_DEPTH bytes, otherwise it is a single holding register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              in,
  output logic [DATA_W-1:0] out,
  output logic              valid,
  input  logic              rd,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
);

`ifdef UART_RX_FIFO_EN
  localparam int unsigned BUF_DEPTH = FIFO_DEPTH;
`else
  localparam int unsigned BUF_DEPTH = 1;
`endif

  localparam int unsigned H          = half_bit(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] START_CNT = CNT_W'((H > 0) ? H - 1 : 0);

  uart_state_e       state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [IDX_W-1:0]  bit_idx, bit_idx_d;
  logic [DATA_W-1:0] shreg, shreg_d;
  logic              push;
  logic              frame_err_d;
  logic              overrun_d;
  logic              buf_full;
  logic              buf_empty;

  uart_rx_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (shreg),
    .pop       (rd),
    .data_out  (out),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  assign valid = !buf_empty;
  assign busy  = (state != IDLE);

  // A good byte is lost only when the buffer is full and no pop frees a slot.
  assign overrun_d = push && buf_full && !(rd && !buf_empty);

  // Next-state logic: counters restart at each sample point; en low aborts.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    bit_idx_d   = bit_idx;
    shreg_d     = shreg;
    push        = 1'b0;
    frame_err_d = 1'b0;
    if (state != IDLE && !en) begin
      state_d   = IDLE;
      cnt_d     = '0;
      bit_idx_d = '0;
    end else begin
      case (state)
        IDLE: begin
          if (en && !in) begin
            cnt_d     = '0;
            bit_idx_d = '0;
            state_d   = (H == 0) ? DATA_BITS : START_BIT;
          end
        end
        START_BIT: begin
          if (cnt == START_CNT) begin
            cnt_d   = '0;
            state_d = in ? IDLE : DATA_BITS;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        DATA_BITS: begin
          if (cnt == LAST_CNT) begin
            cnt_d     = '0;
            shreg_d   = {in, shreg[DATA_W-1:1]};
            bit_idx_d = bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
              state_d = STOP_BIT;
            end
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        STOP_BIT: begin
          if (cnt == LAST_CNT) begin
            cnt_d = '0;
            if (in) begin
              push    = 1'b1;
              state_d = IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = WAIT_HIGH;
            end
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (in) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counters, shift register and event pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      bit_idx   <= bit_idx_d;
      shreg     <= shreg_d;
      frame_err <= frame_err_d;
      overrun   <= overrun_d;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: two instances (16 and 1 clocks per bit)
// compared every cycle against a frame-timing reference model.
module tb_uart_rx;

`ifdef UART_RX_FIFO_EN
  localparam int MD = 4;
`else
  localparam int MD = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n, en;
  logic       line16, line1, rd16, rd1;
  logic [7:0] out16, out1;
  logic       valid16, valid1, busy16, busy1;
  logic       ferr16, ferr1, ovr16, ovr1;

  int checks = 0;
  int failures = 0;
  bit rand_rd = 1'b0;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) u16 (
    .clk(clk), .rst_n(rst_n), .en(en), .in(line16), .out(out16),
    .valid(valid16), .rd(rd16), .busy(busy16), .frame_err(ferr16),
    .overrun(ovr16));

  uart_rx #(.CLKS_PER_BIT(1), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .in(line1), .out(out1),
    .valid(valid1), .rd(rd1), .busy(busy1), .frame_err(ferr1),
    .overrun(ovr1));

  // ---------------- reference model (index 0: 16 clk/bit, 1: 1 clk/bit)
  bit         act [2];
  bit         wh  [2];
  int         rel [2];
  logic [7:0] acc [2];
  logic [7:0] fm  [2][16];
  int         fh  [2];
  int         fc  [2];
  bit         e_valid [2];
  logic [7:0] e_out   [2];
  bit         e_ferr  [2];
  bit         e_ovr   [2];
  bit         e_busy  [2];

  function automatic int cpb_of(input int i);
    return (i == 0) ? 16 : 1;
  endfunction

  task automatic model_step(input int i, input bit r, input bit e,
                            input bit ln, input bit rdv);
    int  cpb;
    int  h;
    int  k;
    bit  push;
    bit  pop;
    cpb = cpb_of(i);
    h = (cpb - 1) / 2;
    push = 1'b0;
    e_ferr[i] = 1'b0;
    e_ovr[i] = 1'b0;
    if (!r) begin
      act[i] = 1'b0; wh[i] = 1'b0; fc[i] = 0; fh[i] = 0;
    end else begin
      pop = rdv && (fc[i] > 0);
      if (act[i]) begin
        if (!e) act[i] = 1'b0;
        else begin
          rel[i]++;
          if (h > 0 && rel[i] == h && ln) act[i] = 1'b0;
          else if (rel[i] > h && (rel[i] - h) % cpb == 0) begin
            k = (rel[i] - h) / cpb;
            if (k <= 8) acc[i][k-1] = ln;
            else begin
              act[i] = 1'b0;
              if (ln) push = 1'b1;
              else begin e_ferr[i] = 1'b1; wh[i] = 1'b1; end
            end
          end
        end
      end else if (wh[i]) begin
        if (!e || ln) wh[i] = 1'b0;
      end else if (e && !ln) begin
        act[i] = 1'b1;
        rel[i] = 0;
      end
      if (pop) begin
        fh[i] = (fh[i] + 1) % 16;
        fc[i]--;
      end
      if (push) begin
        if (fc[i] < MD) begin
          fm[i][(fh[i] + fc[i]) % 16] = acc[i];
          fc[i]++;
        end else e_ovr[i] = 1'b1;
      end
    end
    e_valid[i] = (fc[i] > 0);
    e_out[i]   = (fc[i] > 0) ? fm[i][fh[i]] : 8'h00;
    e_busy[i]  = act[i] || wh[i];
  endtask

  always @(posedge clk) begin
    model_step(0, rst_n, en, line16, rd16);
    model_step(1, rst_n, en, line1, rd1);
  end

  // ---------------- checking
  task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, o, e, $time);
    end
  endtask

  task automatic check_dut(input int i);
    if (i == 0) begin
      chk("u16_valid", {7'd0, valid16}, {7'd0, e_valid[0]});
      chk("u16_out", out16, e_out[0]);
      chk("u16_busy", {7'd0, busy16}, {7'd0, e_busy[0]});
      chk("u16_frame_err", {7'd0, ferr16}, {7'd0, e_ferr[0]});
      chk("u16_overrun", {7'd0, ovr16}, {7'd0, e_ovr[0]});
    end else begin
      chk("u1_valid", {7'd0, valid1}, {7'd0, e_valid[1]});
      chk("u1_out", out1, e_out[1]);
      chk("u1_busy", {7'd0, busy1}, {7'd0, e_busy[1]});
      chk("u1_frame_err", {7'd0, ferr1}, {7'd0, e_ferr[1]});
      chk("u1_overrun", {7'd0, ovr1}, {7'd0, e_ovr[1]});
    end
  endtask

  // One clock: outputs sampled 1 time unit after the edge, then new inputs.
  task automatic cyc();
    @(posedge clk);
    #1;
    check_dut(0);
    check_dut(1);
    if (rand_rd) begin
      rd16 = 1'($urandom % 2);
      rd1  = 1'($urandom % 2);
    end
  endtask

  task automatic set_line(input int i, input logic v);
    if (i == 0) line16 = v; else line1 = v;
  endtask

  task automatic idle(input int n);
    line16 = 1'b1;
    line1  = 1'b1;
    repeat (n) cyc();
  endtask

  // Drive one frame; abort_kind 1 drops en, 2 pulses reset at cycle abort_at.
  task automatic send(input int i, input logic [7:0] b, input logic stop,
                      input int abort_at, input int abort_kind);
    logic [9:0] bits;
    int cpb;
    cpb = cpb_of(i);
    bits = {stop, b, 1'b0};
    for (int n = 0; n < 10 * cpb; n++) begin
      set_line(i, bits[n / cpb]);
      if (n == abort_at) begin
        if (abort_kind == 1) en = 1'b0;
        else rst_n = 1'b0;
      end
      cyc();
      en = 1'b1;
      rst_n = 1'b1;
      if (n == abort_at) begin
        set_line(i, 1'b1);
        return;
      end
    end
  endtask

  // ---------------- stimulus
  initial begin
    rst_n = 1'b0; en = 1'b1; line16 = 1'b1; line1 = 1'b1;
    rd16 = 1'b0; rd1 = 1'b0;
    cyc();
    cyc();
    chk("reset_valid16", {7'd0, valid16}, 8'h00);
    chk("reset_out16", out16, 8'h00);
    rst_n = 1'b1;
    idle(4);

    // Single byte at 1 clk/bit.
    send(1, 8'hA5, 1'b1, -1, 0);
    idle(4);
    chk("a5_out", out1, 8'hA5);
    rd1 = 1'b1; cyc(); rd1 = 1'b0;
    idle(2);

    // Bad stop bit at 16 clk/bit, line held low afterwards.
    send(0, 8'h3C, 1'b0, -1, 0);
    line16 = 1'b0;
    repeat (40) cyc();
    idle(40);
    chk("ferr_no_byte", {7'd0, valid16}, 8'h00);

    // Short low glitch is rejected as a false start.
    line16 = 1'b0;
    repeat (3) cyc();
    idle(20);
    chk("glitch_idle", {7'd0, busy16}, 8'h00);

    // Back-to-back frames into a non-draining buffer, then drain.
    for (int v = 1; v <= 5; v++) send(1, 8'(v), 1'b1, -1, 0);
    idle(3);
    repeat (6) begin rd1 = 1'b1; cyc(); rd1 = 1'b0; cyc(); end

    // en dropped during data bit 3, then a clean frame.
    send(0, 8'h55, 1'b1, 16 * 4 + 3, 1);
    idle(40);
    send(0, 8'h7E, 1'b1, -1, 0);
    idle(20);
    chk("after_abort_out", out16, 8'h7E);

    // Reset mid-frame clears buffered data and outputs.
    send(0, 8'hC3, 1'b1, 16 * 5 + 7, 2);
    chk("rst_valid", {7'd0, valid16}, 8'h00);
    idle(20);

    // Randomised frames with random pops on both instances.
    rand_rd = 1'b1;
    for (int f = 0; f < 10; f++) begin
      send(0, 8'($urandom), ($urandom % 5) != 0, -1, 0);
      for (int g = 0; g < 4; g++)
        send(1, 8'($urandom), ($urandom % 5) != 0, -1, 0);
      idle(int'($urandom % 4));
    end
    rand_rd = 1'b0;
    rd16 = 1'b1; rd1 = 1'b1;
    idle(10);
    rd16 = 1'b0; rd1 = 1'b0;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
